// File: rtl/tpum_pkg.sv
// Shared definitions for the TPU-in-memory sequencer: operation encodings and FSM states.
`default_nettype none

package tpum_pkg;

  localparam logic [1:0] GEMM_OP = 2'b00;
  localparam logic [1:0] BNN_OP  = 2'b01;
  localparam logic [1:0] PUM_OP  = 2'b10;
  localparam logic [1:0] ILL_OP  = 2'b11;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    REQ_A    = 4'd1,
    WAIT_A   = 4'd2,
    REQ_B    = 4'd3,
    WAIT_B   = 4'd4,
    EXEC     = 4'd5,
    WAIT_EXE = 4'd6,
    WRITE    = 4'd7,
    FINISH   = 4'd8
  } state_t;

  function automatic logic mode_legal(input logic [1:0] mode);
    return (mode == GEMM_OP) || (mode == BNN_OP) || (mode == PUM_OP);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tpum_addr_gen.sv
// Operand/result pointer registers and tile counter for the sequencer.
`default_nettype none

module tpum_addr_gen
  import tpum_pkg::*;
#(
  parameter int LINE_W = 1024,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_c,
  input  logic [CNT_W-1:0]  num_tiles,
  output logic [ADDR_W-1:0] cur_a,
  output logic [ADDR_W-1:0] cur_b,
  output logic [ADDR_W-1:0] cur_c,
  output logic              last
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(LINE_W / 8);

  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] idx_nxt;
  logic [CNT_W-1:0] num_q;

  assign idx_nxt = idx + CNT_W'(1);
  // "last" looks at the index the next step would produce.
  assign last    = (idx_nxt == num_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_a <= '0;
      cur_b <= '0;
      cur_c <= '0;
      idx   <= '0;
      num_q <= '0;
    end else if (load) begin
      cur_a <= base_a;
      cur_b <= base_b;
      cur_c <= base_c;
      idx   <= '0;
      num_q <= num_tiles;
    end else if (step) begin
      cur_a <= cur_a + STEP;
      cur_b <= cur_b + STEP;
      cur_c <= cur_c + STEP;
      idx   <= idx_nxt;
    end
  end

endmodule

`default_nettype wire

// File: rtl/tpum_seq_ctrl.sv
// Job sequencer: fetches A/B lines over XBOX, runs the engine, writes the result, per tile.
`default_nettype none

module tpum_seq_ctrl
  import tpum_pkg::*;
#(
  parameter int LINE_W = 1024,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op_mode,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_c,
  input  logic [CNT_W-1:0]  num_tiles,
  output logic              rd_req_valid,
  input  logic              rd_req_ready,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_data_valid,
  input  logic [LINE_W-1:0] rd_data,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [LINE_W-1:0] wr_data,
  output logic [LINE_W-1:0] opa,
  output logic [LINE_W-1:0] opb,
  output logic              exe_start,
  output logic [1:0]        exe_mode,
  input  logic              exe_done,
  input  logic [LINE_W-1:0] exe_result,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        mode_q;
  logic [LINE_W-1:0] opa_q;
  logic [LINE_W-1:0] opb_q;
  logic [LINE_W-1:0] wdata_q;
  logic              done_q;
  logic              err_q;
  logic              load;
  logic              step;
  logic              last;
  logic [ADDR_W-1:0] cur_a;
  logic [ADDR_W-1:0] cur_b;
  logic [ADDR_W-1:0] cur_c;

  assign load = (state == IDLE) && start && mode_legal(op_mode);
  assign step = (state == WRITE) && wr_ready;

  tpum_addr_gen #(
    .LINE_W (LINE_W),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (step),
    .base_a    (base_a),
    .base_b    (base_b),
    .base_c    (base_c),
    .num_tiles (num_tiles),
    .cur_a     (cur_a),
    .cur_b     (cur_b),
    .cur_c     (cur_c),
    .last      (last)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (load) state_nxt = (num_tiles == '0) ? FINISH : REQ_A;
      end
      REQ_A:    if (rd_req_ready)  state_nxt = WAIT_A;
      WAIT_A:   if (rd_data_valid) state_nxt = REQ_B;
      REQ_B:    if (rd_req_ready)  state_nxt = WAIT_B;
      WAIT_B:   if (rd_data_valid) state_nxt = EXEC;
      EXEC:                        state_nxt = WAIT_EXE;
      WAIT_EXE: if (exe_done)      state_nxt = WRITE;
      WRITE:    if (wr_ready)      state_nxt = last ? FINISH : REQ_A;
      FINISH:                      state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mode_q  <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= (state == FINISH);
      err_q  <= (state == IDLE) && start && (op_mode == ILL_OP);
      if (load) mode_q <= op_mode;
      // Read data is only accepted while that read is the one outstanding.
      if ((state == WAIT_A) && rd_data_valid) opa_q <= rd_data;
      if ((state == WAIT_B) && rd_data_valid) opb_q <= rd_data;
      if ((state == WAIT_EXE) && exe_done)    wdata_q <= exe_result;
    end
  end

  // Control outputs are forced low while reset is held, even before the first reset edge.
  assign rd_req_valid = !rst && ((state == REQ_A) || (state == REQ_B));
  assign rd_addr      = (state == REQ_B) ? cur_b : cur_a;
  assign wr_valid     = !rst && (state == WRITE);
  assign wr_addr      = cur_c;
  assign wr_data      = wdata_q;
  assign opa          = opa_q;
  assign opb          = opb_q;
  assign exe_start    = !rst && (state == EXEC);
  assign exe_mode     = mode_q;
  assign busy         = !rst && (state != IDLE);
  assign done         = !rst && done_q;
  assign err          = !rst && err_q;

endmodule

`default_nettype wire
